// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer for Asteroids.
// Owns the title zoom, level start, death/respawn, level-clear and game-over
// phases. All timing is counted in frames (vsync_pulse_i ticks), so the
// behaviour does not depend on the pixel clock rate.
// Optional feature macro: GAME_FLOW_AUTO_RESTART_EN. When defined, OVER
// returns to TITLE after GAMEOVER_FRAMES frames or on a Start press.
// When undefined, OVER is terminal until reset.
module game_flow_ctrl #(
  parameter int TITLE_FRAMES    = 256,
  parameter int READY_FRAMES    = 255,
  parameter int RESPAWN_FRAMES  = 120,
  parameter int INVULN_FRAMES   = 90,
  parameter int CLEAR_FRAMES    = 90,
  parameter int GAMEOVER_FRAMES = 600,
  parameter int LEVEL_W         = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               vsync_pulse_i,
  input  logic               start_btn_i,
  input  logic               die_i,
  input  logic               level_clear_i,
  input  logic               lives_zero_i,
  output logic [2:0]         state_o,
  output logic               title_en_o,
  output logic [7:0]         title_scale_o,
  output logic               game_begin_o,
  output logic               new_level_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               ship_en_o,
  output logic               respawn_o,
  output logic               invuln_o,
  output logic               game_over_o
);

  localparam logic [2:0] S_TITLE = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DEAD  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [9:0] TITLE_LAST   = 10'(TITLE_FRAMES - 1);
  localparam logic [9:0] READY_LAST   = 10'(READY_FRAMES - 1);
  localparam logic [9:0] RESPAWN_LAST = 10'(RESPAWN_FRAMES - 1);
  localparam logic [9:0] CLEAR_LAST   = 10'(CLEAR_FRAMES - 1);
  localparam logic [9:0] INVULN_LOAD  = 10'(INVULN_FRAMES);
`ifdef GAME_FLOW_AUTO_RESTART_EN
  localparam logic [9:0] GAMEOVER_LAST = 10'(GAMEOVER_FRAMES - 1);
`endif

  localparam logic [LEVEL_W-1:0] LEVEL_ONE = {{(LEVEL_W-1){1'b0}}, 1'b1};
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

  logic [2:0]         state_q, state_d;
  logic [9:0]         frameCnt_q, frameCnt_d;
  logic [9:0]         invulnCnt_q, invulnCnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               gameBegin_q, gameBegin_d;
  logic               newLevel_q, newLevel_d;
  logic               respawn_q, respawn_d;
  logic [7:0]         titleScale_q, titleScale_d;
  logic               titleEn_q, shipEn_q, gameOver_q;
  logic               startPrev_q;
  logic               startEdge;

  assign startEdge = start_btn_i & ~startPrev_q;

  // Next-state logic: phase transitions, level/invulnerability bookkeeping
  // and the one-cycle pulses that accompany each transition.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    gameBegin_d  = gameBegin_q;
    newLevel_d   = 1'b0;
    respawn_d    = 1'b0;
    invulnCnt_d  = invulnCnt_q;
    if (vsync_pulse_i && (invulnCnt_q != 10'd0)) begin
      invulnCnt_d = invulnCnt_q - 10'd1;
    end

    case (state_q)
      S_TITLE: begin
        if (startEdge || (vsync_pulse_i && (frameCnt_q == TITLE_LAST))) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (vsync_pulse_i && (frameCnt_q == READY_LAST)) begin
          state_d     = S_PLAY;
          gameBegin_d = 1'b1;
          newLevel_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (die_i && (invulnCnt_q == 10'd0)) begin
          state_d = S_DEAD;
        end else if (level_clear_i) begin
          state_d = S_CLEAR;
        end
      end
      S_DEAD: begin
        if (vsync_pulse_i && (frameCnt_q == RESPAWN_LAST)) begin
          if (lives_zero_i) begin
            state_d = S_OVER;
          end else begin
            state_d     = S_PLAY;
            respawn_d   = 1'b1;
            invulnCnt_d = INVULN_LOAD;
          end
        end
      end
      S_CLEAR: begin
        if (vsync_pulse_i && (frameCnt_q == CLEAR_LAST)) begin
          state_d    = S_PLAY;
          newLevel_d = 1'b1;
          if (level_q != LEVEL_MAX) begin
            level_d = level_q + LEVEL_ONE;
          end
        end
      end
      S_OVER: begin
`ifdef GAME_FLOW_AUTO_RESTART_EN
        if (startEdge || (vsync_pulse_i && (frameCnt_q == GAMEOVER_LAST))) begin
          state_d     = S_TITLE;
          gameBegin_d = 1'b0;
          level_d     = LEVEL_ONE;
        end
`endif
      end
      default: begin
        state_d = S_TITLE;
      end
    endcase
  end

  // Frame counter restarts on every phase change so each phase times itself
  // from zero; the title zoom follows the counter only while in TITLE.
  always_comb begin
    frameCnt_d = frameCnt_q;
    if (state_d != state_q) begin
      frameCnt_d = 10'd0;
    end else if (vsync_pulse_i) begin
      frameCnt_d = frameCnt_q + 10'd1;
    end
    titleScale_d = titleScale_q;
    if (state_d == S_TITLE) begin
      titleScale_d = frameCnt_d[7:0];
    end
  end

  // State and registered outputs. The start edge detector resets high so a
  // button already held when reset releases does not count as a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_TITLE;
      frameCnt_q   <= 10'd0;
      invulnCnt_q  <= 10'd0;
      level_q      <= LEVEL_ONE;
      gameBegin_q  <= 1'b0;
      newLevel_q   <= 1'b0;
      respawn_q    <= 1'b0;
      titleScale_q <= 8'd0;
      titleEn_q    <= 1'b1;
      shipEn_q     <= 1'b0;
      gameOver_q   <= 1'b0;
      startPrev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      frameCnt_q   <= frameCnt_d;
      invulnCnt_q  <= invulnCnt_d;
      level_q      <= level_d;
      gameBegin_q  <= gameBegin_d;
      newLevel_q   <= newLevel_d;
      respawn_q    <= respawn_d;
      titleScale_q <= titleScale_d;
      titleEn_q    <= (state_d == S_TITLE);
      shipEn_q     <= (state_d == S_PLAY);
      gameOver_q   <= (state_d == S_OVER);
      startPrev_q  <= start_btn_i;
    end
  end

  assign state_o       = state_q;
  assign title_en_o    = titleEn_q;
  assign title_scale_o = titleScale_q;
  assign game_begin_o  = gameBegin_q;
  assign new_level_o   = newLevel_q;
  assign level_o       = level_q;
  assign ship_en_o     = shipEn_q;
  assign respawn_o     = respawn_q;
  assign invuln_o      = (invulnCnt_q != 10'd0);
  assign game_over_o   = gameOver_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scenario bench for game_flow_ctrl with shortened phase
// lengths and randomised gaps between frame ticks and event timing.
module tb_game_flow_ctrl;

  localparam int TF  = 4;
  localparam int RF  = 3;
  localparam int SF  = 2;
  localparam int IVF = 2;
  localparam int CF  = 2;
  localparam int GOF = 600;
  localparam int LW  = 4;
  localparam int LMAX = (1 << LW) - 1;

  localparam logic [2:0] ST_TITLE = 3'd0;
  localparam logic [2:0] ST_READY = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_DEAD  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  logic          clock = 1'b0;
  logic          reset, vsync, startBtn, die, levelClear, livesZero;
  logic [2:0]    state;
  logic          titleEn, gameBegin, newLevel, shipEn, respawn, invuln, gameOver;
  logic [7:0]    titleScale;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  game_flow_ctrl #(
    .TITLE_FRAMES(TF), .READY_FRAMES(RF), .RESPAWN_FRAMES(SF),
    .INVULN_FRAMES(IVF), .CLEAR_FRAMES(CF), .GAMEOVER_FRAMES(GOF), .LEVEL_W(LW)
  ) dut (
    .clk_i(clock), .rst_i(reset), .vsync_pulse_i(vsync), .start_btn_i(startBtn),
    .die_i(die), .level_clear_i(levelClear), .lives_zero_i(livesZero),
    .state_o(state), .title_en_o(titleEn), .title_scale_o(titleScale),
    .game_begin_o(gameBegin), .new_level_o(newLevel), .level_o(level),
    .ship_en_o(shipEn), .respawn_o(respawn), .invuln_o(invuln), .game_over_o(gameOver)
  );

  // Free-running pixel clock.
  always #5 clock = ~clock;

  // Hang guard: a stuck run still reports a failure and stops.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic frame();
    repeat ($urandom_range(0, 2)) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic doReset(input logic holdStart);
    reset = 1'b1; startBtn = holdStart; vsync = 1'b0;
    die = 1'b0; levelClear = 1'b0; livesZero = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic gotoPlay();
    doReset(1'b0);
    repeat (TF) frame();
    repeat (RF) frame();
  endtask

  task automatic test_reset();
    logic [18:0] got;
    reset = 1'b1; die = 1'b0; levelClear = 1'b0; livesZero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vsync = 1'($urandom_range(0, 1));
      startBtn = 1'($urandom_range(0, 1));
      tick();
      got = {state, titleEn, titleScale, gameBegin, newLevel, level, shipEn, respawn, invuln, gameOver};
      checks++;
      if (got !== {ST_TITLE, 1'b1, 8'd0, 1'b0, 1'b0, 4'd1, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL reset_state: got %h required %h", got,
                 {ST_TITLE, 1'b1, 8'd0, 1'b0, 1'b0, 4'd1, 4'b0000});
      end
    end
    vsync = 1'b0;
  endtask

  task automatic test_title_timeout();
    doReset(1'b0);
    for (int k = 1; k < TF; k++) begin
      frame();
      checks++;
      if ({state, titleEn, titleScale} !== {ST_TITLE, 1'b1, 8'(k)}) begin
        errors++;
        $display("[TB] FAIL title_zoom: got state %0d en %b scale %0d required state 0 en 1 scale %0d",
                 state, titleEn, titleScale, k);
      end
    end
    frame();
    checks++;
    if ({state, titleEn, shipEn} !== {ST_READY, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL title_timeout: got state %0d en %b required state 1 en 0", state, titleEn);
    end
    for (int k = 1; k < RF; k++) begin
      frame();
      checks++;
      if ({state, gameBegin} !== {ST_READY, 1'b0}) begin
        errors++;
        $display("[TB] FAIL ready_hold: got state %0d begin %b required state 1 begin 0", state, gameBegin);
      end
    end
    frame();
    checks++;
    if ({state, newLevel, gameBegin, shipEn, level} !== {ST_PLAY, 1'b1, 1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL ready_to_play: got state %0d nl %b gb %b ship %b lvl %0d required 2 1 1 1 1",
               state, newLevel, gameBegin, shipEn, level);
    end
    tick();
    checks++;
    if ({newLevel, gameBegin} !== {1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL new_level_pulse: got nl %b gb %b required nl 0 gb 1", newLevel, gameBegin);
    end
  endtask

  task automatic test_start_skip();
    doReset(1'b0);
    frame();
    checks++;
    if ({state, titleScale} !== {ST_TITLE, 8'd1}) begin
      errors++;
      $display("[TB] FAIL start_pre: got state %0d scale %0d required 0 1", state, titleScale);
    end
    startBtn = 1'b1;
    tick();
    checks++;
    if ({state, titleEn, titleScale} !== {ST_READY, 1'b0, 8'd1}) begin
      errors++;
      $display("[TB] FAIL start_skip: got state %0d en %b scale %0d required 1 0 1", state, titleEn, titleScale);
    end
    repeat (RF - 1) frame();
    checks++;
    if (state !== ST_READY) begin
      errors++;
      $display("[TB] FAIL start_ready_hold: got state %0d required 1", state);
    end
    frame();
    checks++;
    if ({state, newLevel} !== {ST_PLAY, 1'b1}) begin
      errors++;
      $display("[TB] FAIL start_play: got state %0d nl %b required 2 1", state, newLevel);
    end
    startBtn = 1'b0;
  endtask

  task automatic test_die_respawn();
    int invulnLeft;
    gotoPlay();
    die = 1'b1; levelClear = 1'b1;
    tick();
    die = 1'b0; levelClear = 1'b0;
    checks++;
    if ({state, shipEn} !== {ST_DEAD, 1'b0}) begin
      errors++;
      $display("[TB] FAIL die_wins: got state %0d ship %b required 3 0", state, shipEn);
    end
    livesZero = 1'b0;
    repeat (SF - 1) frame();
    checks++;
    if (state !== ST_DEAD) begin
      errors++;
      $display("[TB] FAIL dead_hold: got state %0d required 3", state);
    end
    frame();
    checks++;
    if ({state, respawn, invuln, shipEn, newLevel} !== {ST_PLAY, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL respawn: got state %0d rs %b inv %b ship %b nl %b required 2 1 1 1 0",
               state, respawn, invuln, shipEn, newLevel);
    end
    tick();
    checks++;
    if (respawn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL respawn_pulse: got %b required 0", respawn);
    end
    invulnLeft = IVF;
    for (int v = 0; v < IVF; v++) begin
      repeat ($urandom_range(0, 2)) tick();
      die = 1'b1;
      tick();
      die = 1'b0;
      checks++;
      if (state !== ST_PLAY) begin
        errors++;
        $display("[TB] FAIL invuln_ignore: got state %0d required 2", state);
      end
      frame();
      invulnLeft--;
      checks++;
      if (invuln !== (invulnLeft != 0)) begin
        errors++;
        $display("[TB] FAIL invuln_count: got %b required %b", invuln, (invulnLeft != 0));
      end
    end
    die = 1'b1;
    tick();
    die = 1'b0;
    checks++;
    if (state !== ST_DEAD) begin
      errors++;
      $display("[TB] FAIL die_after_invuln: got state %0d required 3", state);
    end
  endtask

  task automatic test_clear_level();
    int expLevel;
    int n;
    gotoPlay();
    expLevel = 1;
    n = LMAX + int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      levelClear = 1'b1;
      tick();
      levelClear = 1'b0;
      checks++;
      if ({state, shipEn} !== {ST_CLEAR, 1'b0}) begin
        errors++;
        $display("[TB] FAIL clear_enter: got state %0d ship %b required 4 0", state, shipEn);
      end
      repeat (CF - 1) frame();
      frame();
      expLevel = (expLevel < LMAX) ? expLevel + 1 : LMAX;
      checks++;
      if ({state, newLevel, invuln, level} !== {ST_PLAY, 1'b1, 1'b0, 4'(expLevel)}) begin
        errors++;
        $display("[TB] FAIL next_level: got state %0d nl %b inv %b lvl %0d required 2 1 0 %0d",
                 state, newLevel, invuln, level, expLevel);
      end
      tick();
      checks++;
      if (newLevel !== 1'b0) begin
        errors++;
        $display("[TB] FAIL next_level_pulse: got %b required 0", newLevel);
      end
    end
  endtask

  task automatic reachOver();
    die = 1'b1;
    tick();
    die = 1'b0;
    livesZero = 1'b1;
    repeat (SF) frame();
    checks++;
    if ({state, gameOver, shipEn} !== {ST_OVER, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL enter_over: got state %0d go %b ship %b required 5 1 0", state, gameOver, shipEn);
    end
  endtask

  task automatic test_game_over();
    gotoPlay();
    levelClear = 1'b1;
    tick();
    levelClear = 1'b0;
    repeat (CF) frame();
    reachOver();
    startBtn = 1'b0;
    tick();
    startBtn = 1'b1;
    tick();
    startBtn = 1'b0;
`ifdef GAME_FLOW_AUTO_RESTART_EN
    checks++;
    if ({state, level, gameBegin, titleEn, gameOver} !== {ST_TITLE, 4'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL over_start_restart: got state %0d lvl %0d gb %b en %b go %b required 0 1 0 1 0",
               state, level, gameBegin, titleEn, gameOver);
    end
    livesZero = 1'b0;
    repeat (TF + RF) frame();
    levelClear = 1'b1;
    tick();
    levelClear = 1'b0;
    repeat (CF) frame();
    reachOver();
    repeat (GOF - 1) frame();
    checks++;
    if (state !== ST_OVER) begin
      errors++;
      $display("[TB] FAIL over_hold: got state %0d required 5", state);
    end
    frame();
    checks++;
    if ({state, level, gameBegin, titleEn} !== {ST_TITLE, 4'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL over_timeout: got state %0d lvl %0d gb %b en %b required 0 1 0 1",
               state, level, gameBegin, titleEn);
    end
`else
    checks++;
    if ({state, gameOver} !== {ST_OVER, 1'b1}) begin
      errors++;
      $display("[TB] FAIL over_start_ignored: got state %0d go %b required 5 1", state, gameOver);
    end
    repeat (GOF + 50) frame();
    checks++;
    if ({state, gameOver, level} !== {ST_OVER, 1'b1, 4'd2}) begin
      errors++;
      $display("[TB] FAIL over_terminal: got state %0d go %b lvl %0d required 5 1 2", state, gameOver, level);
    end
`endif
    livesZero = 1'b0;
  endtask

  task automatic test_held_start();
    doReset(1'b1);
    repeat (5) tick();
    checks++;
    if (state !== ST_TITLE) begin
      errors++;
      $display("[TB] FAIL held_start_noskip: got state %0d required 0", state);
    end
    repeat (TF - 1) frame();
    checks++;
    if ({state, titleScale} !== {ST_TITLE, 8'(TF - 1)}) begin
      errors++;
      $display("[TB] FAIL held_start_title: got state %0d scale %0d required 0 %0d", state, titleScale, TF - 1);
    end
    frame();
    checks++;
    if (state !== ST_READY) begin
      errors++;
      $display("[TB] FAIL held_start_ready: got state %0d required 1", state);
    end
    startBtn = 1'b0;
  endtask

  task automatic test_midop_reset();
    logic [18:0] got;
    gotoPlay();
    levelClear = 1'b1;
    tick();
    levelClear = 1'b0;
    repeat (CF) frame();
    levelClear = 1'b1;
    tick();
    levelClear = 1'b0;
    reset = 1'b1;
    tick();
    got = {state, titleEn, titleScale, gameBegin, newLevel, level, shipEn, respawn, invuln, gameOver};
    checks++;
    if (got !== {ST_TITLE, 1'b1, 8'd0, 1'b0, 1'b0, 4'd1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL midop_reset: got %h required %h", got,
               {ST_TITLE, 1'b1, 8'd0, 1'b0, 1'b0, 4'd1, 4'b0000});
    end
    reset = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    reset = 1'b1; vsync = 1'b0; startBtn = 1'b0;
    die = 1'b0; levelClear = 1'b0; livesZero = 1'b0;
    test_reset();
    test_title_timeout();
    test_start_skip();
    test_die_respawn();
    test_clear_level();
    test_game_over();
    test_held_start();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
